// File: rtl/adc_result_serializer_pkg.sv
// Shared definitions for the ADC result readout path: word width, serializer
// states and counter sizing helpers.
package adc_result_serializer_pkg;

    localparam int RESULT_OSR_BITS = 16;
    localparam int BIT_CNT_W       = $clog2(RESULT_OSR_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } ser_state_t;

    // Divider counter must hold 2*CLK_DIV-1 for the inter-word gap.
    function automatic int div_cnt_w(input int clk_div);
        return (clk_div < 1) ? 1 : $clog2(2 * clk_div);
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Small synchronous FIFO holding captured ADC results until the serializer
// takes them. A push into a full FIFO is ignored unless a pop frees a slot.
module adc_result_fifo
    import adc_result_serializer_pkg::*;
#(
    parameter int WIDTH = RESULT_OSR_BITS,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/adc_result_serializer.sv
// Captures ADC results on conversion_finished rising edges, buffers them and
// ships each word MSB-first as a framed serial stream with a divided bit clock.
//   state | meaning
//   IDLE  | waiting for a buffered word; pops the head into the shift register
//   LOAD  | raises frame and presents the MSB
//   SHIFT | bit clock low/high halves, data advances on the falling edge
//   GAP   | ser_clk held low for one bit period between words
module adc_result_serializer
    import adc_result_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [RESULT_OSR_BITS-1:0]     i_result_osr,
    input  logic                           i_conversion_finished_osr,
    input  logic                           i_enable,
    input  logic                           i_clear_ovf,
    output logic                           o_ser_clk,
    output logic                           o_ser_data,
    output logic                           o_ser_frame,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level,
    output logic                           o_overflow,
    output logic                           o_busy
);

    localparam int DIV_W = div_cnt_w(CLK_DIV);
    localparam int MSB   = RESULT_OSR_BITS - 1;

    ser_state_t                  r_state;
    ser_state_t                  w_state_next;
    logic                        r_prev_cf;
    logic                        r_overflow;
    logic                        r_ser_clk;
    logic                        r_ser_data;
    logic                        r_ser_frame;
    logic [DIV_W-1:0]            r_div_cnt;
    logic [BIT_CNT_W-1:0]        r_bit_cnt;
    logic [RESULT_OSR_BITS-1:0]  r_shift;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_half_done;
    logic [RESULT_OSR_BITS-1:0]  w_head;
    logic [$clog2(FIFO_DEPTH):0] w_level;

    assign w_push      = i_conversion_finished_osr & ~r_prev_cf & i_enable;
    assign w_pop       = (r_state == IDLE) & ~w_empty;
    assign w_half_done = (r_div_cnt == '0);

    adc_result_fifo #(
        .WIDTH (RESULT_OSR_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_result_osr),
        .o_data  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (!w_empty) w_state_next = LOAD;
            LOAD:    w_state_next = SHIFT;
            SHIFT:   if (w_half_done && r_ser_clk && (r_bit_cnt == '0)) w_state_next = GAP;
            GAP:     if (w_half_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_cf   <= 1'b1;
            r_overflow  <= 1'b0;
            r_ser_clk   <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_frame <= 1'b0;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
        end else begin
            r_prev_cf <= i_conversion_finished_osr;
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (i_clear_ovf)           r_overflow <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_pop) r_shift <= w_head;
                end
                LOAD: begin
                    r_ser_frame <= 1'b1;
                    r_ser_data  <= r_shift[MSB];
                    r_shift     <= r_shift << 1;
                    r_ser_clk   <= 1'b0;
                    r_bit_cnt   <= BIT_CNT_W'(RESULT_OSR_BITS - 1);
                    r_div_cnt   <= DIV_W'(CLK_DIV - 1);
                end
                SHIFT: begin
                    if (!w_half_done) begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end else if (!r_ser_clk) begin
                        r_ser_clk <= 1'b1;
                        r_div_cnt <= DIV_W'(CLK_DIV - 1);
                    end else if (r_bit_cnt == '0) begin
                        r_ser_clk   <= 1'b0;
                        r_ser_frame <= 1'b0;
                        r_ser_data  <= 1'b0;
                        r_div_cnt   <= DIV_W'(2 * CLK_DIV - 1);
                    end else begin
                        r_ser_clk  <= 1'b0;
                        r_ser_data <= r_shift[MSB];
                        r_shift    <= r_shift << 1;
                        r_bit_cnt  <= r_bit_cnt - 1'b1;
                        r_div_cnt  <= DIV_W'(CLK_DIV - 1);
                    end
                end
                GAP: begin
                    if (!w_half_done) r_div_cnt <= r_div_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_ser_clk    = r_ser_clk;
    assign o_ser_data   = r_ser_data;
    assign o_ser_frame  = r_ser_frame;
    assign o_fifo_level = w_level;
    assign o_overflow   = r_overflow;
    assign o_busy       = (r_state != IDLE) || (w_level != '0);

endmodule

// File: tb/tb_adc_result_serializer.sv
// Bench for adc_result_serializer: directed scenarios plus random traffic,
// checked every cycle against a word-level timing model of the readout.
module tb_adc_result_serializer;
    import adc_result_serializer_pkg::*;

    localparam int W      = 16;
    localparam int DEPTH  = 4;
    localparam int DIV    = 2;
    localparam int BITP   = 2 * DIV;
    localparam int FRAME  = W * BITP;
    localparam int PERIOD = 1 + (W + 1) * BITP + 1;

    logic          clk = 1'b0;
    logic          rst, cf, en, clr;
    logic [W-1:0]  din;
    logic          o_ser_clk, o_ser_data, o_ser_frame, o_overflow, o_busy;
    logic [2:0]    o_fifo_level;

    adc_result_serializer #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_result_osr              (din),
        .i_conversion_finished_osr (cf),
        .i_enable                  (en),
        .i_clear_ovf               (clr),
        .o_ser_clk                 (o_ser_clk),
        .o_ser_data                (o_ser_data),
        .o_ser_frame               (o_ser_frame),
        .o_fifo_level              (o_fifo_level),
        .o_overflow                (o_overflow),
        .o_busy                    (o_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Word-level model: FIFO contents, when the serializer is free, and the word in flight.
    int           k = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] sent_q[$];
    int           free_at = 0;
    int           last_pop = -1000;
    logic [W-1:0] cur_word = '0;
    logic         m_ovf = 1'b0;
    logic         m_prev = 1'b1;
    int           peak = 0;

    task automatic model_step();
        bit pop, push, full_pre, drop;
        k++;
        if (rst) begin
            mq.delete();
            if (k <= last_pop + FRAME && sent_q.size() > 0) void'(sent_q.pop_back());
            m_ovf = 1'b0; m_prev = 1'b1; free_at = k + 1; last_pop = -1000;
            return;
        end
        full_pre = (mq.size() == DEPTH);
        pop  = (k >= free_at) && (mq.size() > 0);
        push = cf && !m_prev && en;
        if (pop) begin
            cur_word = mq.pop_front();
            sent_q.push_back(cur_word);
            last_pop = k;
            free_at  = k + PERIOD;
        end
        drop = push && full_pre && !pop;
        if (push && !drop) mq.push_back(din);
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_prev = cf;
    endtask

    function automatic logic [7:0] exp_out();
        int   o;
        int   idx;
        logic fr, sc, sd, bz;
        o   = k - (last_pop + 1);
        fr  = (o >= 0) && (o < FRAME);
        sc  = fr && ((o % BITP) >= DIV);
        idx = fr ? (W - 1 - o / BITP) : 0;
        sd  = fr ? cur_word[idx] : 1'b0;
        bz  = (k <= last_pop + PERIOD - 2) || (mq.size() > 0);
        return {fr, sc, sd, m_ovf, bz, 3'(mq.size())};
    endfunction

    function automatic logic [7:0] obs_out();
        return {o_ser_frame, o_ser_clk, o_ser_data, o_overflow, o_busy, o_fifo_level};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cycle", obs_out(), exp_out());
        if (int'(o_fifo_level) > peak) peak = int'(o_fifo_level);
    endtask

    // Receiver: samples ser_data on each rising ser_clk inside a frame.
    logic [W-1:0] mon_sr = '0;
    int           mon_n = 0;
    logic         mon_pf = 1'b0, mon_pc = 1'b0;
    logic [W-1:0] got_q[$];

    always @(posedge clk) begin
        #1;
        if (o_ser_frame && !mon_pf) mon_n = 0;
        if (o_ser_clk && !mon_pc && o_ser_frame) begin
            mon_sr = {mon_sr[W-2:0], o_ser_data};
            mon_n++;
        end
        if (!o_ser_frame && mon_pf && mon_n == W) got_q.push_back(mon_sr);
        mon_pf = o_ser_frame;
        mon_pc = o_ser_clk;
    end

    task automatic do_reset();
        rst = 1'b1; tick();
        rst = 1'b0; cf = 1'b0; tick();
    endtask

    task automatic capture(input logic [W-1:0] v);
        din = v; cf = 1'b1; tick();
        cf = 1'b0; din = W'($urandom); tick();
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!o_busy) break;
            tick();
        end
        chk("drain", o_busy, 0);
    endtask

    function automatic logic [W-1:0] last_word();
        return (got_q.size() > 0) ? got_q[got_q.size()-1] : 'x;
    endfunction

    initial begin
        int k_cap, rise, fall, bl, hi, pre;
        rst = 1'b1; cf = 1'b0; en = 1'b1; clr = 1'b0; din = '0;
        tick();
        chk("reset_out", obs_out(), 0);
        rst = 1'b0; tick();

        // 1: single capture timing and bit order
        din = 16'hA5C3; cf = 1'b1; tick(); k_cap = k;
        cf = 1'b0;
        rise = -1; fall = -1; bl = -1; hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_ser_frame) begin
                hi++;
                if (rise < 0) rise = k;
            end else if (rise >= 0 && fall < 0) fall = k;
            if (fall >= 0 && bl < 0 && !o_busy) bl = k;
        end
        chk("t1_latency", rise - k_cap, 2);
        chk("t1_frame_len", hi, FRAME);
        chk("t1_gap", bl - fall, BITP);
        chk("t1_word", last_word(), 16'hA5C3);

        // 2: burst overflows the FIFO
        do_reset();
        pre = got_q.size(); peak = 0;
        for (int i = 1; i <= 6; i++) begin
            din = W'(i); cf = 1'b1; tick();
            cf = 1'b0; tick(); tick();
        end
        chk("t2_ovf", o_overflow, 1);
        wait_idle(600);
        chk("t2_peak", peak, DEPTH);
        chk("t2_nwords", got_q.size() - pre, 5);
        for (int j = 0; j < 5; j++)
            chk("t2_word", (pre + j < got_q.size()) ? got_q[pre+j] : 'x, j + 1);

        // 3: held level captures once; level high across reset is ignored
        do_reset();
        pre = got_q.size();
        din = 16'h3C5A; cf = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        cf = 1'b0; tick();
        wait_idle(200);
        chk("t3_held_once", got_q.size() - pre, 1);
        cf = 1'b1; rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t3_post_rst_level", o_fifo_level, 0);
        chk("t3_post_rst_busy", o_busy, 0);
        cf = 1'b0; tick();

        // 4: enable gating
        en = 1'b0; din = 16'h1111; cf = 1'b1; tick();
        cf = 1'b0; tick(); tick(); tick();
        chk("t4_level", o_fifo_level, 0);
        chk("t4_frame", o_ser_frame, 0);
        en = 1'b1;

        // 5: set wins over clear
        do_reset();
        for (int i = 0; i < 5; i++) capture(W'($urandom));
        din = 16'hDEAD; cf = 1'b1; clr = 1'b1; tick();
        chk("t5_set_wins", o_overflow, 1);
        cf = 1'b0; tick();
        chk("t5_cleared", o_overflow, 0);
        clr = 1'b0;
        wait_idle(600);

        // 6: reset mid-word, then a clean word
        do_reset();
        din = 16'h1234; cf = 1'b1; tick();
        cf = 1'b0;
        for (int i = 0; i < 2 + 7 * BITP + 1; i++) tick();
        rst = 1'b1; tick();
        chk("t6_rst", {o_ser_frame, o_ser_clk, o_busy, o_fifo_level}, 0);
        rst = 1'b0; tick();
        capture(16'h00FF);
        wait_idle(200);
        chk("t6_word", last_word(), 16'h00FF);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 3) == 0) cf = ~cf;
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 19) == 0);
            din = W'($urandom);
            tick();
        end
        rst = 1'b0; cf = 1'b0; clr = 1'b0; en = 1'b1;
        tick();
        wait_idle(600);
        tick(); tick();

        chk("words_total", got_q.size(), sent_q.size());
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
            chk("word_stream", got_q[i], sent_q[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
